// File: rtl/pc_seq_if.sv
// pc_seq_if : control/status bundle between the fetch controller and pc_seq.
// rev 1.0
`default_nettype none

interface pc_seq_if #(
  parameter int D  = 10,
  parameter int SD = 4
);
  localparam int DW = $clog2(SD + 1);

  logic          stall;
  logic          halt;
  logic          jb_en;
  logic          br_en;
  logic          call_en;
  logic          ret_en;
  logic [D-1:0]  target;
  logic [D-1:0]  offset;
  logic [D-1:0]  prog_ctr;
  logic          halted;
  logic [DW-1:0] depth;
  logic          stk_err;

  modport master (
    output stall, halt, jb_en, br_en, call_en, ret_en, target, offset,
    input  prog_ctr, halted, depth, stk_err
  );

  modport slave (
    input  stall, halt, jb_en, br_en, call_en, ret_en, target, offset,
    output prog_ctr, halted, depth, stk_err
  );
endinterface

`default_nettype wire

// File: rtl/pc_seq.sv
// pc_seq : program counter / sequencer with jump, branch, call/return stack,
// stall and halt.  rev 1.0
`default_nettype none

module pc_seq #(
  parameter int           D     = 10,
  parameter int           SD    = 4,
  parameter logic [D-1:0] START = '0
) (
  input  wire logic  clk,
  input  wire logic  reset,
  pc_seq_if.slave    bus
);
  localparam int DW = $clog2(SD + 1);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [D-1:0]  pc, pc_nx;
  logic [DW-1:0] depth, depth_nx;
  logic          err, err_nx;
  logic          push;
  logic [D-1:0]  pc_inc;
  logic [AW-1:0] push_idx, top_idx;

  // Power-of-two sized so any AW-bit index is in range, even when SD is not.
  logic [D-1:0]  stack [0:(1 << AW) - 1];

  assign pc_inc   = pc + D'(1);
  assign push_idx = AW'(depth);
  assign top_idx  = AW'(depth - DW'(1));

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    depth_nx = depth;
    err_nx   = err;
    push     = 1'b0;
    if (state == RUN && !bus.stall) begin
      if (bus.halt) begin
        state_nx = HALT;
      end else if (bus.ret_en) begin
        if (depth != '0) begin
          pc_nx    = stack[top_idx];
          depth_nx = depth - DW'(1);
        end else begin
          pc_nx  = pc_inc;
          err_nx = 1'b1;
        end
      end else if (bus.call_en) begin
        pc_nx = bus.target;
        // A full stack still takes the jump; only the push is lost.
        if (depth < DW'(SD)) begin
          push     = 1'b1;
          depth_nx = depth + DW'(1);
        end else begin
          err_nx = 1'b1;
        end
      end else if (bus.jb_en) begin
        pc_nx = bus.target;
      end else if (bus.br_en) begin
        pc_nx = pc + bus.offset;
      end else begin
        pc_nx = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= START;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      depth <= depth_nx;
      err   <= err_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack[push_idx] <= pc_inc;
    end
  end

  assign bus.prog_ctr = pc;
  assign bus.halted   = (state == HALT);
  assign bus.depth    = depth;
  assign bus.stk_err  = err;
endmodule

`default_nettype wire

// File: tb/tb_pc_seq.sv
// tb_pc_seq : vector-table bench for pc_seq with an expected-result queue.
// rev 1.0
`default_nettype none

module tb_pc_seq;
  localparam int           D     = 10;
  localparam int           SD    = 4;
  localparam logic [D-1:0] START = 10'h010;

  // control bit positions: {reset, stall, halt, ret, call, jb, br}
  localparam logic [6:0] IDL = 7'b0000000;
  localparam logic [6:0] RST = 7'b1000000;
  localparam logic [6:0] STL = 7'b0100000;
  localparam logic [6:0] HLT = 7'b0010000;
  localparam logic [6:0] RET = 7'b0001000;
  localparam logic [6:0] CAL = 7'b0000100;
  localparam logic [6:0] JMP = 7'b0000010;
  localparam logic [6:0] BRA = 7'b0000001;

  typedef struct packed {
    logic [6:0] ctl;
    logic [9:0] tgt;
    logic [9:0] off;
    logic [9:0] pc;
    logic [2:0] dep;
    logic       hlt;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  vec_t exp_q[$];
  vec_t vecs[$];

  pc_seq_if #(.D(D), .SD(SD)) bus ();

  pc_seq #(.D(D), .SD(SD), .START(START)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [6:0] c, input logic [9:0] t, input logic [9:0] o,
                              input logic [9:0] p, input logic [2:0] d, input logic h,
                              input logic e);
    vec_t v;
    v.ctl = c; v.tgt = t; v.off = o; v.pc = p; v.dep = d; v.hlt = h; v.err = e;
    return v;
  endfunction

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    {reset, bus.stall, bus.halt, bus.ret_en, bus.call_en, bus.jb_en, bus.br_en} = v.ctl;
    bus.target = v.tgt;
    bus.offset = v.off;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (bus.prog_ctr !== e.pc || bus.depth !== e.dep || bus.halted !== e.hlt ||
        bus.stk_err !== e.err) begin
      fails++;
      $display("FAIL vec%0d: got pc=%h depth=%0d halted=%b err=%b, want pc=%h depth=%0d halted=%b err=%b",
               idx, bus.prog_ctr, bus.depth, bus.halted, bus.stk_err, e.pc, e.dep, e.hlt, e.err);
    end
  endtask

  initial begin
    reset = 1'b1;
    {bus.stall, bus.halt, bus.ret_en, bus.call_en, bus.jb_en, bus.br_en} = '0;
    bus.target = '0;
    bus.offset = '0;

    // reset, idle increment, wrap-around, negative branch
    vecs.push_back(mk(RST, 10'h000, 10'h000, 10'h010, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h011, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h012, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h013, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(JMP, 10'h3FE, 10'h000, 10'h3FE, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h3FF, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h000, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h001, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h002, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(BRA, 10'h000, 10'h3FC, 10'h3FE, 3'd0, 1'b0, 1'b0));
    // single call / return
    vecs.push_back(mk(JMP, 10'h020, 10'h000, 10'h020, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(CAL, 10'h100, 10'h000, 10'h100, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(RET, 10'h000, 10'h000, 10'h021, 3'd0, 1'b0, 1'b0));
    // nested calls to overflow, returns to underflow
    vecs.push_back(mk(CAL, 10'h200, 10'h000, 10'h200, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(CAL, 10'h210, 10'h000, 10'h210, 3'd2, 1'b0, 1'b0));
    vecs.push_back(mk(CAL, 10'h220, 10'h000, 10'h220, 3'd3, 1'b0, 1'b0));
    vecs.push_back(mk(CAL, 10'h230, 10'h000, 10'h230, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(CAL, 10'h240, 10'h000, 10'h240, 3'd4, 1'b0, 1'b1));
    vecs.push_back(mk(RET, 10'h000, 10'h000, 10'h221, 3'd3, 1'b0, 1'b1));
    vecs.push_back(mk(RET, 10'h000, 10'h000, 10'h211, 3'd2, 1'b0, 1'b1));
    vecs.push_back(mk(RET, 10'h000, 10'h000, 10'h201, 3'd1, 1'b0, 1'b1));
    vecs.push_back(mk(RET, 10'h000, 10'h000, 10'h022, 3'd0, 1'b0, 1'b1));
    vecs.push_back(mk(RET, 10'h000, 10'h000, 10'h023, 3'd0, 1'b0, 1'b1));
    // stall holds, call+ret gives ret only
    vecs.push_back(mk(STL | JMP, 10'h055, 10'h000, 10'h023, 3'd0, 1'b0, 1'b1));
    vecs.push_back(mk(STL | JMP, 10'h055, 10'h000, 10'h023, 3'd0, 1'b0, 1'b1));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h024, 3'd0, 1'b0, 1'b1));
    vecs.push_back(mk(CAL, 10'h300, 10'h000, 10'h300, 3'd1, 1'b0, 1'b1));
    vecs.push_back(mk(CAL | RET, 10'h333, 10'h000, 10'h025, 3'd0, 1'b0, 1'b1));
    // halt and recovery by reset
    vecs.push_back(mk(JMP, 10'h040, 10'h000, 10'h040, 3'd0, 1'b0, 1'b1));
    vecs.push_back(mk(HLT, 10'h000, 10'h000, 10'h040, 3'd0, 1'b1, 1'b1));
    vecs.push_back(mk(JMP, 10'h055, 10'h000, 10'h040, 3'd0, 1'b1, 1'b1));
    vecs.push_back(mk(CAL, 10'h155, 10'h000, 10'h040, 3'd0, 1'b1, 1'b1));
    vecs.push_back(mk(RST, 10'h000, 10'h000, 10'h010, 3'd0, 1'b0, 1'b0));
    // stalled halt is ignored; branch sum wraps; reset beats stall
    vecs.push_back(mk(STL | HLT, 10'h000, 10'h000, 10'h010, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(IDL, 10'h000, 10'h000, 10'h011, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(JMP | BRA, 10'h3FE, 10'h005, 10'h3FE, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(BRA, 10'h000, 10'h005, 10'h003, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(RST | STL, 10'h000, 10'h000, 10'h010, 3'd0, 1'b0, 1'b0));

    foreach (vecs[i]) step(vecs[i], i);

    // stalled call must neither jump nor push; the stack must survive it
    step(mk(CAL, 10'h180, 10'h000, 10'h180, 3'd1, 1'b0, 1'b0), 100);
    for (int k = 0; k < 3; k++)
      step(mk(STL | CAL, 10'h2AA, 10'h000, 10'h180, 3'd1, 1'b0, 1'b0), 101 + k);
    step(mk(CAL, 10'h3FF, 10'h000, 10'h3FF, 3'd2, 1'b0, 1'b0), 104);
    step(mk(RET, 10'h000, 10'h000, 10'h181, 3'd1, 1'b0, 1'b0), 105);
    step(mk(RET, 10'h000, 10'h000, 10'h011, 3'd0, 1'b0, 1'b0), 106);
    // call from the top address pushes a wrapped return address
    step(mk(JMP, 10'h3FF, 10'h000, 10'h3FF, 3'd0, 1'b0, 1'b0), 107);
    step(mk(CAL, 10'h070, 10'h000, 10'h070, 3'd1, 1'b0, 1'b0), 108);
    step(mk(RET, 10'h000, 10'h000, 10'h000, 3'd0, 1'b0, 1'b0), 109);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
